// File: rtl/connect_join_rr.sv
// Purpose : N-to-1 valid/ready join, round-robin arbitration into a registered output FIFO.
// Latency : one cycle from accept to SEND_VALID; no combinational input-to-output path.
// Backpr. : RECEIVE_READY depends only on FIFO fullness (never on SEND_READY); a full FIFO refuses pushes.
//
// Ports:
//   CLK, RST       clock and synchronous active-high reset
//   RECEIVE_VALID  per-channel valid             RECEIVE_DATA  packed payloads, channel i at [DW*(i+1)-1 -: DW]
//   RECEIVE_READY  one-hot (or zero) accept strobe for the granted channel
//   SEND_VALID     FIFO not empty                SEND_DATA / SEND_SRC  head payload and its source channel
//   SEND_READY     consumer pops the head when high with SEND_VALID
module connect_join_rr #(
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int SRC_WIDTH   = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
  output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
  output logic                              SEND_VALID,
  output logic [DATA_WIDTH-1:0]             SEND_DATA,
  output logic [SRC_WIDTH-1:0]              SEND_SRC,
  input  logic                              SEND_READY
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [SRC_WIDTH-1:0]  src;
    logic [DATA_WIDTH-1:0] dat;
  } entry_t;

  entry_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [SRC_WIDTH-1:0] last_grant;

  logic                  full;
  logic                  hi_found, lo_found;
  logic [SRC_WIDTH-1:0]  hi_idx, lo_idx;
  logic                  grant_vld;
  logic [SRC_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] grant_dat;
  logic                  push, pop;

  assign full = (count == CNT_W'(FIFO_DEPTH));

  // Rotating priority without a modulo: the lowest valid channel above
  // last_grant wins; if there is none, wrap to the lowest valid channel at or
  // below it. Loops run downward so the final assignment is the lowest index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = CONNECT_NUM - 1; i >= 0; i--) begin
      if (RECEIVE_VALID[i]) begin
        if (i > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = SRC_WIDTH'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = SRC_WIDTH'(i);
        end
      end
    end
    grant_vld = hi_found | lo_found;
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // Ready is gated by RST so nothing appears accepted during a reset cycle.
  always_comb begin
    RECEIVE_READY = '0;
    grant_dat     = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (grant_idx == SRC_WIDTH'(i)) begin
        RECEIVE_READY[i] = grant_vld & ~full & ~RST;
        grant_dat        = RECEIVE_DATA[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign push = |(RECEIVE_VALID & RECEIVE_READY);
  assign pop  = SEND_VALID & SEND_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_grant <= SRC_WIDTH'(CONNECT_NUM - 1);
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever presented.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= '{src: grant_idx, dat: grant_dat};
    end
  end

  assign SEND_VALID = (count != '0);
  assign SEND_DATA  = mem[rd_ptr].dat;
  assign SEND_SRC   = mem[rd_ptr].src;

endmodule

// File: tb/tb_connect_join_rr.sv
module tb_connect_join_rr;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int D  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    rv;
  logic [DW*N-1:0] rd;
  logic [N-1:0]    rr;
  logic            sv;
  logic [DW-1:0]   sd;
  logic [SW-1:0]   ss;
  logic            srdy;

  always #5 clk = ~clk;

  connect_join_rr #(.DATA_WIDTH(DW), .CONNECT_NUM(N), .FIFO_DEPTH(D), .SRC_WIDTH(SW)) dut (
    .CLK(clk), .RST(rst),
    .RECEIVE_VALID(rv), .RECEIVE_DATA(rd), .RECEIVE_READY(rr),
    .SEND_VALID(sv), .SEND_DATA(sd), .SEND_SRC(ss), .SEND_READY(srdy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of accepted entries plus the index of
  // the last accepted channel.
  typedef struct {
    int          src;
    logic [DW-1:0] dat;
  } ent_t;

  ent_t mq[$];
  int   lg = N - 1;
  logic m_push = 1'b0;
  logic m_pop  = 1'b0;
  ent_t m_ent;
  int   m_g;

  task automatic apply(input logic r, input logic [N-1:0] v, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic s);
    rst  = r;
    rv   = v;
    rd   = {d2, d1, d0};
    srdy = s;
    #1;
  endtask

  task automatic model_check(input string tag);
    int g;
    logic [N-1:0] exp_rr;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int ch;
      ch = (lg + k) % N;
      if (g < 0 && rv[ch]) g = ch;
    end
    exp_rr = '0;
    m_push = 1'b0;
    if (!rst && g >= 0 && mq.size() < D) begin
      exp_rr[g] = 1'b1;
      m_push    = 1'b1;
      m_g       = g;
      m_ent.src = g;
      m_ent.dat = rd[DW*g +: DW];
    end
    m_pop = (mq.size() != 0) && srdy;
    chk({tag, " model ready"}, rr, exp_rr);
    chk({tag, " model send_valid"}, sv, mq.size() != 0);
    if (mq.size() != 0) begin
      chk({tag, " model send_data"}, sd, mq[0].dat);
      chk({tag, " model send_src"}, ss, mq[0].src);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      lg = N - 1;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(m_ent);
        lg = m_g;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  vld;
    logic [DW-1:0] d2;
    logic          srdy;
    logic [N-1:0]  e_rr;
    logic          e_sv;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_src;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [N-1:0] v, input logic [DW-1:0] d2,
                              input logic s, input logic [N-1:0] err, input logic esv,
                              input logic [DW-1:0] edat, input logic [SW-1:0] esrc);
    vec_t x;
    x.rst = r; x.vld = v; x.d2 = d2; x.srdy = s;
    x.e_rr = err; x.e_sv = esv; x.e_dat = edat; x.e_src = esrc;
    return x;
  endfunction

  initial begin
    logic [DW-1:0] c2;
    c2 = 32'hA2;
    // Round-robin flow, all valid, consumer ready.
    tbl.push_back(mk(1, 3'b000, c2, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, c2, 1, 3'b001, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, c2, 1, 3'b010, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 3'b111, c2, 1, 3'b100, 1, 32'hA1, 1));
    tbl.push_back(mk(0, 3'b111, c2, 1, 3'b001, 1, 32'hA2, 2));
    tbl.push_back(mk(0, 3'b111, c2, 1, 3'b010, 1, 32'hA0, 0));
    // Reset, then fill to full with consumer stalled.
    tbl.push_back(mk(1, 3'b111, c2, 0, 3'b000, 1, 32'hA1, 1));
    tbl.push_back(mk(0, 3'b111, c2, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, c2, 0, 3'b010, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 3'b111, c2, 0, 3'b100, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 3'b111, c2, 0, 3'b001, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 3'b111, c2, 0, 3'b000, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 3'b111, c2, 0, 3'b000, 1, 32'hA0, 0));
    // Full with a pop: no push this cycle, push of ch1 next cycle.
    tbl.push_back(mk(0, 3'b111, c2, 1, 3'b000, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 3'b111, c2, 1, 3'b010, 1, 32'hA1, 1));
    tbl.push_back(mk(0, 3'b000, c2, 1, 3'b000, 1, 32'hA2, 2));
    tbl.push_back(mk(0, 3'b000, c2, 1, 3'b000, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 3'b000, c2, 1, 3'b000, 1, 32'hA1, 1));
    tbl.push_back(mk(0, 3'b000, c2, 1, 3'b000, 0, 0, 0));
    // Only ch2 valid, then ch0+ch2: wrap gives ch0 first.
    tbl.push_back(mk(0, 3'b100, 32'h55, 1, 3'b100, 0, 0, 0));
    tbl.push_back(mk(0, 3'b100, 32'h55, 1, 3'b100, 1, 32'h55, 2));
    tbl.push_back(mk(0, 3'b100, 32'h55, 1, 3'b100, 1, 32'h55, 2));
    tbl.push_back(mk(0, 3'b101, 32'h55, 1, 3'b001, 1, 32'h55, 2));
    tbl.push_back(mk(0, 3'b101, 32'h55, 1, 3'b100, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 3'b000, 32'h55, 1, 3'b000, 1, 32'h55, 2));
    // Single channel streaming: occupancy stays at one, no bubbles.
    tbl.push_back(mk(0, 3'b010, c2, 1, 3'b010, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, c2, 1, 3'b010, 1, 32'hA1, 1));
    tbl.push_back(mk(0, 3'b010, c2, 1, 3'b010, 1, 32'hA1, 1));
    // Build 3 entries, reset with inputs valid.
    tbl.push_back(mk(0, 3'b111, c2, 0, 3'b100, 1, 32'hA1, 1));
    tbl.push_back(mk(0, 3'b111, c2, 0, 3'b001, 1, 32'hA1, 1));
    tbl.push_back(mk(1, 3'b111, c2, 0, 3'b000, 1, 32'hA1, 1));
    tbl.push_back(mk(0, 3'b111, c2, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, c2, 1, 3'b000, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 3'b000, c2, 0, 3'b000, 0, 0, 0));

    apply(1'b1, '0, 32'hA0, 32'hA1, c2, 1'b0);
    advance();

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(tbl[i].rst, tbl[i].vld, 32'hA0, 32'hA1, tbl[i].d2, tbl[i].srdy);
      model_check(tag);
      chk({tag, " ready"}, rr, tbl[i].e_rr);
      chk({tag, " send_valid"}, sv, tbl[i].e_sv);
      if (tbl[i].e_sv) begin
        chk({tag, " send_data"}, sd, tbl[i].e_dat);
        chk({tag, " send_src"}, ss, tbl[i].e_src);
      end
      advance();
    end

    // Randomized traffic with phases of light and heavy backpressure.
    for (int c = 0; c < 3000; c++) begin
      logic          r, s;
      logic [N-1:0]  v;
      int            bp;
      bp = (c / 200) % 3;
      r  = ($urandom_range(0, 99) == 0);
      v  = N'($urandom);
      case (bp)
        0:       s = 1'b1;
        1:       s = ($urandom_range(0, 3) == 0);
        default: s = ($urandom_range(0, 1) == 0);
      endcase
      apply(r, v, $urandom, $urandom, $urandom, s);
      model_check($sformatf("rnd%0d", c));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
